afe_emulator: RTL and testbench
===============================

Name: afe_emulator

Overview:
- Synthesizable behavioural model of the pulse-oximeter analog front end: LED, photodiode, DC compensation DAC, PGA and 8-bit ADC.
- It is the responder to the oximeter controller. It consumes LED_RED, LED_IR, LED_DRIVE, DC_Comp and PGA_Gain, and returns the ADC sample stream.
- Used in the closed-loop bench and on the FPGA demo build in place of the real analog board.

Parameters:
- RED_DC, 150, red photodiode baseline (pre-drive units, 8 bit).
- IR_DC, 170, IR photodiode baseline (8 bit).
- RED_AC, 12, red pulsatile peak amplitude (8 bit).
- IR_AC, 20, IR pulsatile peak amplitude (8 bit).
- AMBIENT, 16, signal when neither or both LEDs are on.
- COMP_STEP, 2, optical units removed per DC_Comp LSB.
- PULSE_DIV, 4, clock cycles per pulse-waveform step.
- SETTLE_CYCLES, 4, blanking cycles after any setting change.

Ports:
- CLK  in  1  system clock
- rst  in  1  asynchronous reset, active high
- LED_RED  in  1  red LED enable
- LED_IR  in  1  IR LED enable
- LED_DRIVE  in  4  LED current code
- DC_Comp  in  7  DC compensation code
- PGA_Gain  in  4  PGA gain code
- ADC  out  8  emulated ADC sample
- ADC_valid  out  1  high when ADC reflects settled, current settings

Behaviour:
- Reset values: ADC=8'd128, ADC_valid=0, waveform w=0 with direction up, divider=0, state=IDLE, settle counter=0, all input shadow registers=0.
- Pulse generator:
  - 8-bit triangle w, one step every PULSE_DIV cycles.
  - Counts 0→255, then 255→0, and repeats. The turn-around takes no extra step: 254,255,254.
  - Channel AC term = (w * X_AC) >> 8.
- Stage 1 (registered), optical signal s (12 bit unsigned):
  - LED_RED=1 and LED_IR=0: s = ((RED_DC + ac_red) * LED_DRIVE) >> 3.
  - LED_IR=1 and LED_RED=0: s = ((IR_DC + ac_ir) * LED_DRIVE) >> 3.
  - Otherwise: s = AMBIENT, independent of LED_DRIVE.
- Stage 1, compensation: d = s − COMP_STEP*DC_Comp, held as 13-bit signed.
- Stage 2 (registered), gain and conversion:
  - a = (d * (PGA_Gain+1)) >>> 2, arithmetic shift, 18-bit signed.
  - ADC = clamp(a+128, 0, 255).
- Latency: ADC reflects inputs sampled exactly 2 clock edges earlier.
- Shadow registers capture LED_RED, LED_IR, LED_DRIVE, DC_Comp and PGA_Gain every cycle. A change is any difference between an input and its shadow.
- State machine (drives ADC_valid):
  - IDLE: entered from reset; ADC_valid=0. Moves to SETTLE on the first edge where either LED is high or any setting changes.
  - SETTLE: loads the counter with SETTLE_CYCLES+2 and decrements each edge. ADC keeps updating; ADC_valid=0. Moves to TRACK when the counter reaches 0.
  - TRACK: ADC_valid=1. Any change returns to SETTLE and reloads the counter on that same edge.
- A change while already in SETTLE reloads the counter, so settling restarts.
- LED handover with simultaneous toggling (red→IR in one cycle) counts as a single change.
- Reset mid-operation returns everything to the reset values immediately, including mid-SETTLE and mid-waveform.

Optional Feature:
- Macro AFE_NOISE_EN.
- Defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - Its low 3 bits minus 3 (range −3..+4) are added to a before the clamp.
- Undefined: the LFSR is absent and ADC is fully deterministic.

Decomposition:
- Package afe_pkg holds:
  - width constants ADC_W=8, DAC_W=7, GAIN_W=4, DRV_W=4;
  - the state enum (IDLE, SETTLE, TRACK);
  - the LFSR seed and taps.
- Sub-module afe_pulse_gen contains the triangle generator (divider plus up/down counter). It outputs w.

Test Plan:
- Release rst, hold every input at 0 → ADC stays 128 and ADC_valid stays 0; FSM remains IDLE.
- Ambient path: LED_RED=0, LED_IR=0, DC_Comp=0, PGA_Gain=0, with a one-cycle DC_Comp pulse to start settling → after 6 cycles ADC_valid=1 and ADC=132.
- Red path: LED_RED=1, LED_DRIVE=10, DC_Comp=40, PGA_Gain=3, sampled while w=0 (just after reset) → ADC=235.
- Low clamp: both LEDs off, DC_Comp=127, PGA_Gain=15 → ADC=0. Saturation in the opposite direction (LED_IR=1, LED_DRIVE=15, DC_Comp=0, PGA_Gain=15) → ADC=255.
- Settling: in TRACK, change PGA_Gain 3→4 → ADC_valid is low on the next edge and stays low 6 cycles. Changing again at cycle 3 extends the low window by a further 6 cycles.
- Waveform and reset:
  - Red settings from the red-path case held for 2040 cycles: w rises to 255 then falls, and ADC stays in range with the expected peak.
  - Assert rst mid-ramp → ADC=128, ADC_valid=0 and w=0 within the same cycle.

Source files
------------

// File: rtl/afe_pkg.sv
// Purpose: shared widths, FSM state encoding and LFSR constants for the AFE emulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package afe_pkg;

  localparam int ADC_W  = 8;
  localparam int DAC_W  = 7;
  localparam int GAIN_W = 4;
  localparam int DRV_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    TRACK  = 2'd2
  } state_t;

  // Right-shifting Galois LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/afe_pulse_gen.sv
// Purpose: 8-bit triangle waveform (0..255..0) stepping once every PULSE_DIV cycles.
// Latency: w is a register; one step per PULSE_DIV edges, no extra step at the turn-arounds.
// Backpressure: none, free-running.
// Ports: i_clk clock, i_rst async active-high reset, o_w current waveform value.
module afe_pulse_gen
  import afe_pkg::*;
#(
  parameter int PULSE_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic [7:0] o_w
);

  localparam int DIV_W = (PULSE_DIV > 1) ? $clog2(PULSE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PULSE_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_up;
  logic [7:0]       r_w;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div <= '0;
      r_up  <= 1'b1;
      r_w   <= 8'd0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      // Reversing at an end point is itself the step: ...254,255,254...
      if (r_up) begin
        if (r_w == 8'd255) begin
          r_up <= 1'b0;
          r_w  <= 8'd254;
        end else begin
          r_w <= r_w + 8'd1;
        end
      end else begin
        if (r_w == 8'd0) begin
          r_up <= 1'b1;
          r_w  <= 8'd1;
        end else begin
          r_w <= r_w - 8'd1;
        end
      end
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign o_w = r_w;

endmodule

// File: rtl/afe_emulator.sv
// Purpose: behavioural pulse-oximeter AFE (LEDs, photodiode, DC comp DAC, PGA, 8-bit ADC).
// Latency: o_adc reflects inputs sampled two edges earlier; o_adc_valid once settled.
// Backpressure: none, one sample per cycle; o_adc holds 128 while idle.
// Ports: i_clk, i_rst (async active-high), i_led_red/i_led_ir LED enables,
//        i_led_drive LED current, i_dc_comp DC comp code, i_pga_gain PGA gain,
//        o_adc emulated sample, o_adc_valid settled indication.
// Build option: define AFE_NOISE_EN to add LFSR noise (-3..+4) before the clamp.
module afe_emulator
  import afe_pkg::*;
#(
  parameter int RED_DC        = 150,
  parameter int IR_DC         = 170,
  parameter int RED_AC        = 12,
  parameter int IR_AC         = 20,
  parameter int AMBIENT       = 16,
  parameter int COMP_STEP     = 2,
  parameter int PULSE_DIV     = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_led_red,
  input  logic              i_led_ir,
  input  logic [DRV_W-1:0]  i_led_drive,
  input  logic [DAC_W-1:0]  i_dc_comp,
  input  logic [GAIN_W-1:0] i_pga_gain,
  output logic [ADC_W-1:0]  o_adc,
  output logic              o_adc_valid
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES + 2);

  // Pulse waveform and per-channel AC terms.
  logic [7:0] w_w;
  logic [7:0] w_ac_red;
  logic [7:0] w_ac_ir;

  afe_pulse_gen #(.PULSE_DIV(PULSE_DIV)) u_pulse (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .o_w   (w_w)
  );

  assign w_ac_red = 8'((16'(w_w) * 16'(RED_AC)) >> 8);
  assign w_ac_ir  = 8'((16'(w_w) * 16'(IR_AC)) >> 8);

  // Stage 1: optical signal minus DC compensation.
  logic [11:0]        w_s;
  logic [12:0]        w_comp;
  logic signed [12:0] w_d;
  logic signed [12:0] r_d;

  always_comb begin
    w_s = 12'(AMBIENT);
    if (i_led_red && !i_led_ir) begin
      w_s = 12'((13'(RED_DC + w_ac_red) * 13'(i_led_drive)) >> 3);
    end else if (i_led_ir && !i_led_red) begin
      w_s = 12'((13'(IR_DC + w_ac_ir) * 13'(i_led_drive)) >> 3);
    end
  end

  assign w_comp = 13'(COMP_STEP) * 13'(i_dc_comp);
  assign w_d    = $signed({1'b0, w_s} - w_comp);

  // Shadow registers: change detection, and the gain shadow doubles as the
  // stage-1 copy of PGA_Gain so gain and d stay aligned in the pipeline.
  logic              r_sh_red;
  logic              r_sh_ir;
  logic [DRV_W-1:0]  r_sh_drive;
  logic [DAC_W-1:0]  r_sh_comp;
  logic [GAIN_W-1:0] r_sh_gain;
  logic              w_change;

  assign w_change = (i_led_red != r_sh_red) || (i_led_ir != r_sh_ir) ||
                    (i_led_drive != r_sh_drive) || (i_dc_comp != r_sh_comp) ||
                    (i_pga_gain != r_sh_gain);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_d        <= '0;
      r_sh_red   <= 1'b0;
      r_sh_ir    <= 1'b0;
      r_sh_drive <= '0;
      r_sh_comp  <= '0;
      r_sh_gain  <= '0;
    end else begin
      r_d        <= w_d;
      r_sh_red   <= i_led_red;
      r_sh_ir    <= i_led_ir;
      r_sh_drive <= i_led_drive;
      r_sh_comp  <= i_dc_comp;
      r_sh_gain  <= i_pga_gain;
    end
  end

  // Stage 2: PGA gain, optional noise, offset and clamp.
  logic [4:0]         w_gain_p1;
  logic signed [17:0] w_prod;
  logic signed [17:0] w_a;
  logic signed [17:0] w_noise;
  logic signed [17:0] w_sum;
  logic [ADC_W-1:0]   w_adc_nxt;
  logic [ADC_W-1:0]   r_adc;

  assign w_gain_p1 = {1'b0, r_sh_gain} + 5'd1;
  assign w_prod    = 18'(r_d) * $signed({13'd0, w_gain_p1});
  assign w_a       = w_prod >>> 2;

`ifdef AFE_NOISE_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign w_noise = $signed({15'd0, r_lfsr[2:0]}) - 18'sd3;
`else
  assign w_noise = 18'sd0;
`endif

  assign w_sum = w_a + w_noise + 18'sd128;

  always_comb begin
    w_adc_nxt = w_sum[ADC_W-1:0];
    if (w_sum < 18'sd0) begin
      w_adc_nxt = 8'd0;
    end else if (w_sum > 18'sd255) begin
      w_adc_nxt = 8'd255;
    end
  end

  // Settling FSM.
  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_adc_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_led_red || i_led_ir || w_change) begin
          w_state_nxt = SETTLE;
          w_cnt_nxt   = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (w_change) begin
          w_cnt_nxt = SETTLE_LOAD;
        end else if (r_cnt <= 4'd1) begin
          w_state_nxt = TRACK;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      TRACK: begin
        o_adc_valid = 1'b1;
        if (w_change) begin
          w_state_nxt = SETTLE;
          w_cnt_nxt   = SETTLE_LOAD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // The sample register is frozen at mid-scale until the first activity.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_adc <= 8'd128;
    end else if (r_state != IDLE) begin
      r_adc <= w_adc_nxt;
    end
  end

  assign o_adc = r_adc;

endmodule

// File: tb/tb_afe_emulator.sv
// Purpose: directed self-checking bench for afe_emulator (noise option off).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_afe_emulator;
  import afe_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       led_red, led_ir;
  logic [3:0] led_drive;
  logic [6:0] dc_comp;
  logic [3:0] pga_gain;
  logic [7:0] adc;
  logic       adc_valid;

  int total = 0;
  int bad   = 0;

  afe_emulator dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_led_red   (led_red),
    .i_led_ir    (led_ir),
    .i_led_drive (led_drive),
    .i_dc_comp   (dc_comp),
    .i_pga_gain  (pga_gain),
    .o_adc       (adc),
    .o_adc_valid (adc_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    led_red   = 1'b0;
    led_ir    = 1'b0;
    led_drive = 4'd0;
    dc_comp   = 7'd0;
    pga_gain  = 4'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    zero_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic red_settings();
    led_red   = 1'b1;
    led_ir    = 1'b0;
    led_drive = 4'd10;
    dc_comp   = 7'd40;
    pga_gain  = 4'd3;
  endtask

  // Triangle value after n edges since reset release (one step per 4 edges).
  function automatic int tri_w(input int n);
    int k;
    k = (n / 4) % 510;
    return (k <= 255) ? k : 510 - k;
  endfunction

  initial begin
    int n;
    int max_adc;
    int min_adc;

    // Idle: all inputs zero, nothing should happen.
    do_reset();
    repeat (20) step();
    check("idle_adc", int'(adc), 128);
    check("idle_valid", int'(adc_valid), 0);
    check("idle_state", int'(dut.r_state), int'(IDLE));

    // Ambient path with a one-cycle DC_Comp pulse.
    do_reset();
    dc_comp = 7'd1;
    step();
    dc_comp = 7'd0;
    step();
    repeat (5) step();
    check("amb_valid_low", int'(adc_valid), 0);
    step();
    check("amb_valid_high", int'(adc_valid), 1);
    check("amb_adc", int'(adc), 132);

    // Red path at w=0: ((150*10)>>3)-80 = 107, gain 4/4 -> 107+128 = 235.
    do_reset();
    red_settings();
    step();
    check("red_adc_e0", int'(adc), 128);
    step();
    check("red_adc", int'(adc), 235);
    repeat (5) step();
    check("red_valid", int'(adc_valid), 1);

    // Settling: gain 3->4 in TRACK.
    pga_gain = 4'd4;
    step();
    check("set1_first_low", int'(adc_valid), 0);
    repeat (5) step();
    check("set1_last_low", int'(adc_valid), 0);
    step();
    check("set1_high", int'(adc_valid), 1);
    check("gain4_adc", int'(adc), 255);  // 107*5>>2 = 133, +128 clamps

    // Second change on the third cycle of a settle window restarts it.
    pga_gain = 4'd5;
    step();
    step();
    pga_gain = 4'd6;
    step();
    repeat (5) step();
    check("set2_last_low", int'(adc_valid), 0);
    step();
    check("set2_high", int'(adc_valid), 1);

    // Waveform: red settings held over a full triangle period.
    do_reset();
    red_settings();
    max_adc = 0;
    min_adc = 255;
    n = 0;
    for (int i = 0; i < 2040; i++) begin
      step();
      n++;
      if (n >= 2) begin
        if (int'(adc) > max_adc) max_adc = int'(adc);
        if (int'(adc) < min_adc) min_adc = int'(adc);
      end
      if (n == 1020) check("w_peak", int'(dut.w_w), 255);
      if (n == 1500) check("w_falling", int'(dut.w_w), tri_w(1500));
    end
    check("w_end", int'(dut.w_w), tri_w(n));
    // Peak at w=255: ac=11, ((161*10)>>3)-80 = 121 -> 249.
    check("wave_max", max_adc, 249);
    check("wave_min", min_adc, 235);
    check("wave_valid", int'(adc_valid), 1);

    // Reset mid-ramp, between edges.
    repeat (100) step();
    #2;
    rst = 1'b1;
    #1;
    check("rst_adc", int'(adc), 128);
    check("rst_valid", int'(adc_valid), 0);
    check("rst_w", int'(dut.w_w), 0);
    step();
    rst = 1'b0;

    // Low clamp: 16 - 254 = -238, *16 >>> 2 = -952 -> 0.
    zero_inputs();
    dc_comp  = 7'd127;
    pga_gain = 4'd15;
    step();
    step();
    check("clamp_low", int'(adc), 0);

    // High clamp: IR at full drive, no compensation, max gain.
    led_ir    = 1'b1;
    led_drive = 4'd15;
    dc_comp   = 7'd0;
    step();
    step();
    check("clamp_high", int'(adc), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
